// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage bus between the datapath and the HI/LO multiply/divide unit.
// The datapath drives the request and read-select signals; the unit drives status and HI/LO values.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [1:0]       HiLo;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] read_data;

    modport master (
        output start, op_div, rs_data, rt_data, HiLo,
        input  busy, done, stall, hi, lo, read_data
    );

    modport slave (
        input  start, op_div, rs_data, rt_data, HiLo,
        output busy, done, stall, hi, lo, read_data
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle signed multiply/divide unit owning HI/LO: magnitudes are iterated for WIDTH cycles
// (shift-add or restoring division), then signs are applied in a single FIX cycle.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic                CLK,
    input logic                RESET,
    hilo_muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             op_div_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic             divzero_reg;
    logic [WIDTH-1:0] rs_raw_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [WIDTH-1:0] work_hi_reg;
    logic [WIDTH-1:0] work_lo_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             busy_reg;
    logic             done_reg;

    // Operand magnitudes; |-2^(WIDTH-1)| is still correct when read as unsigned.
    logic [WIDTH-1:0] mag_rs;
    logic [WIDTH-1:0] mag_rt;
    logic             accept;
    logic             divzero_in;
    logic             last_iter;

    assign mag_rs     = bus.rs_data[WIDTH-1] ? (~bus.rs_data + 1'b1) : bus.rs_data;
    assign mag_rt     = bus.rt_data[WIDTH-1] ? (~bus.rt_data + 1'b1) : bus.rt_data;
    assign accept     = (state_reg == IDLE) && bus.start;
    assign divzero_in = bus.op_div && (bus.rt_data == '0);
    assign last_iter  = (cnt_reg == CNT_W'(WIDTH - 1));

    // Shift-add step: work_hi accumulates, work_lo holds the remaining multiplier bits
    // and collects the low product bits as they shift in from the top.
    logic [WIDTH:0]   mult_sum;
    logic [WIDTH-1:0] mult_hi_next;
    logic [WIDTH-1:0] mult_lo_next;

    assign mult_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mult_hi_next = mult_sum[WIDTH:1];
    assign mult_lo_next = {mult_sum[0], work_lo_reg[WIDTH-1:1]};

    // Restoring step: work_hi is the partial remainder, work_lo shifts the dividend out
    // of the top and the quotient bits in at the bottom.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign div_shift   = {work_hi_reg, work_lo_reg[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opnd_reg};
    assign div_ok      = ~div_diff[WIDTH];
    assign div_hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_next = {work_lo_reg[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_result;
    logic [WIDTH-1:0]   lo_result;

    assign prod_mag = {work_hi_reg, work_lo_reg};
    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? (~work_lo_reg + 1'b1) : work_lo_reg;
    assign rem_fix  = sign_a_reg ? (~work_hi_reg + 1'b1) : work_hi_reg;

    always_comb begin
        hi_result = prod_fix[2*WIDTH-1:WIDTH];
        lo_result = prod_fix[WIDTH-1:0];
        if (op_div_reg) begin
            if (divzero_reg) begin
                hi_result = rs_raw_reg;
                lo_result = '1;
            end else begin
                hi_result = rem_fix;
                lo_result = quo_fix;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = divzero_in ? FIX : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            divzero_reg <= 1'b0;
            rs_raw_reg  <= '0;
            opnd_reg    <= '0;
            work_hi_reg <= '0;
            work_lo_reg <= '0;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_div_reg  <= bus.op_div;
                        sign_a_reg  <= bus.rs_data[WIDTH-1];
                        sign_b_reg  <= bus.rt_data[WIDTH-1];
                        divzero_reg <= divzero_in;
                        rs_raw_reg  <= bus.rs_data;
                        opnd_reg    <= bus.op_div ? mag_rt : mag_rs;
                        work_lo_reg <= bus.op_div ? mag_rs : mag_rt;
                        work_hi_reg <= '0;
                        cnt_reg     <= '0;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (op_div_reg) begin
                        work_hi_reg <= div_hi_next;
                        work_lo_reg <= div_lo_next;
                    end else begin
                        work_hi_reg <= mult_hi_next;
                        work_lo_reg <= mult_lo_next;
                    end
                end
                FIX: begin
                    hi_reg <= hi_result;
                    lo_reg <= lo_result;
                end
                default: ;
            endcase
        end
    end

    logic             sel_hi;
    logic             sel_lo;
    logic [WIDTH-1:0] read_bits;

    assign sel_hi = (bus.HiLo == 2'b10);
    assign sel_lo = (bus.HiLo == 2'b01);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_read_mux
        assign read_bits[gi] = (sel_hi & hi_reg[gi]) | (sel_lo & lo_reg[gi]);
    end

    assign bus.read_data = read_bits;
    assign bus.stall     = busy_reg & (sel_hi | sel_lo);
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: stimulus pushes expected HI/LO into a queue,
// a monitor pops and compares them on every done pulse.
module tb_hilo_muldiv_unit;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(
        .WIDTH(32),
        .CNT_W(5)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: hi=%h lo=%h with no operation outstanding", bus.hi, bus.lo);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", bus.hi, e[63:32]);
                    check("result_lo", bus.lo, e[31:0]);
                end
            end
        end
    end

    task automatic do_op(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int exp_busy,
                         input logic [1:0] hold_sel, input logic [31:0] hold_val, input int inject_at);
        int cycles;
        exp_q.push_back({eh, el});
        @(negedge CLK);
        bus.start   = 1'b1;
        bus.op_div  = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.HiLo    = hold_sel;
        @(negedge CLK);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (hold_sel != 2'b00) begin
                check({name, "_stall_busy"}, {31'd0, bus.stall}, 32'd1);
                check({name, "_read_old"}, bus.read_data, hold_val);
            end
            if (cycles == inject_at) begin
                bus.start   = 1'b1;
                bus.op_div  = 1'b0;
                bus.rs_data = 32'd9;
                bus.rt_data = 32'd9;
            end
            @(negedge CLK);
            bus.start = 1'b0;
        end
        check({name, "_busy_cycles"}, cycles, exp_busy);
        check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd1);
        if (hold_sel != 2'b00) begin
            check({name, "_stall_after"}, {31'd0, bus.stall}, 32'd0);
        end
        $display("op %s: op_div=%0d rs=%h rt=%h -> hi=%h lo=%h busy_cycles=%0d",
                 name, op, a, b, bus.hi, bus.lo, cycles);
        bus.HiLo = 2'b00;
        @(negedge CLK);
        check({name, "_done_low"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic read_check(input string name, input logic [1:0] sel,
                              input logic [31:0] exp_data, input logic exp_stall);
        bus.HiLo = sel;
        #1;
        check({name, "_read_data"}, bus.read_data, exp_data);
        check({name, "_stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
        $display("read %s: HiLo=%b -> read_data=%h stall=%0d", name, sel, bus.read_data, bus.stall);
        bus.HiLo = 2'b00;
    endtask

    initial begin
        RESET       = 1'b1;
        bus.start   = 1'b0;
        bus.op_div  = 1'b0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.HiLo    = 2'b00;
        repeat (2) @(negedge CLK);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        RESET = 1'b0;

        do_op("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 2'b00, 32'd0, 0);
        read_check("mflo", 2'b01, 32'hFFFF_FFEB, 1'b0);
        read_check("mfhi", 2'b10, 32'hFFFF_FFFF, 1'b0);
        read_check("sel11", 2'b11, 32'd0, 1'b0);

        do_op("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 2'b00, 32'd0, 0);
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 2'b00, 32'd0, 0);
        do_op("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 33, 2'b00, 32'd0, 0);
        do_op("div_100_0", 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 2'b00, 32'd0, 0);
        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 2'b00, 32'd0, 0);

        do_op("prime_hi", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 33, 2'b00, 32'd0, 0);
        do_op("mult_5_6_mfhi", 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 33, 2'b10, 32'h4000_0000, 0);
        read_check("mfhi_new", 2'b10, 32'd0, 1'b0);

        do_op("mult_5_6_restart", 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 33, 2'b00, 32'd0, 10);

        // Abort a divide mid-flight; the aborted op never produces a done.
        @(negedge CLK);
        bus.start   = 1'b1;
        bus.op_div  = 1'b1;
        bus.rs_data = 32'd1000;
        bus.rt_data = 32'd7;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (14) @(negedge CLK);
        check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        RESET = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        $display("abort: RESET mid-divide -> busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        @(negedge CLK);
        RESET = 1'b0;

        do_op("div_1000_7", 1'b1, 32'd1000, 32'd7, 32'd6, 32'd142, 33, 2'b00, 32'd0, 0);

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never arrived, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle signed multiply/divide unit that owns the HI/LO register pair.
- Executes mult/div as decoded by the main control decoder, and serves mfhi/mflo reads selected by the decoder's 2-bit HiLo output.
- Sits beside the ALU in the execute stage.
- Issues a stall to the datapath while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled on a rising edge.
- op_div  input  1  0 = mult, 1 = div.
- rs_data  input  WIDTH  multiplicand / dividend (signed).
- rt_data  input  WIDTH  multiplier / divisor (signed).
- HiLo  input  2  read select: 00 none, 01 LO (mflo), 10 HI (mfhi), 11 treated as 00.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated.
- stall  output  1  read requested while busy.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- read_data  output  WIDTH  selected HI/LO value for the register write-back mux.

Behaviour:
- Reset: state=IDLE; hi, lo, counter and working registers = 0; busy=0, done=0.
  - RESET asserted mid-operation aborts the operation.
  - HI/LO are not updated by the aborted operation; they read 0 after reset.
- States: IDLE, RUN, FIX.
- IDLE, start=1 on an edge:
  - Latch op_div.
  - Latch magnitudes |rs_data| and |rt_data|, plus sign flags.
  - Counter = 0, go to RUN.
- Divide by zero: op_div=1 and rt_data=0 goes directly to FIX with the divzero flag set.
- RUN:
  - One iteration per cycle, exactly WIDTH (32) cycles; counter 0..31.
  - After iteration 31, go to FIX.
  - mult: unsigned shift-add on magnitudes into a 2*WIDTH product.
  - div: restoring division on magnitudes, one quotient bit per cycle.
- FIX, one cycle; on exit edge write HI/LO, go to IDLE:
  - mult: {hi,lo} = product, negated (two's complement, 64-bit) when the operand signs differ.
  - div: lo = quotient, negated when the signs differ; hi = remainder, negated when the dividend is negative.
  - divzero: hi = rs_data as latched, lo = all ones.
  - -2^31 / -1 produces lo=0x80000000, hi=0 (wraps, no trap).
- busy:
  - Registered; 1 in RUN and FIX, 0 in IDLE.
  - Normal op: busy is high for 33 cycles after the start edge.
  - Divide by zero: busy is high for 1 cycle.
- done:
  - Registered; 1 for exactly the cycle after the FIX edge, i.e. the first IDLE cycle, when the new hi/lo are visible.
- start while busy=1 is ignored: operands are not re-latched and the current op continues.
- start in the same cycle done=1 is accepted (state is IDLE).
- stall = busy & (HiLo==01 | HiLo==10); combinational.
- read_data:
  - Combinational: HiLo=10 gives hi, HiLo=01 gives lo, otherwise 0.
  - While busy, read_data shows the old hi/lo; the consumer must honour stall.
- hi/lo change only on the FIX exit edge or on reset.

Test Plan:
1. Reset, then mult rs=7, rt=0xFFFFFFFD (-3) -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; HiLo=01 gives read_data=0xFFFFFFEB.
2. mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000; then div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. div rs=100, rt=0 -> busy high 1 cycle, done next cycle; hi=100, lo=0xFFFFFFFF. Separately, div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Prime hi=0x40000000 (from scenario 2), then start mult 5*6 and hold HiLo=10 -> stall=1 and read_data=0x40000000 throughout busy; stall=0 once done; hi=0, lo=30.
5. Start mult 5*6; at busy cycle 10 pulse start with mult 9*9 -> the second start is ignored; final lo=30, and total busy stays 33 cycles.
6. Start div 1000/7; assert RESET at busy cycle 15 -> busy=0, done=0, hi=lo=0 immediately (async); deassert RESET, then start div 1000/7 -> lo=142, hi=6.
